// File: rtl/taus_urng_pkg.sv
// rtl/taus_urng_pkg.sv - taus88 constants, channel-state type and seed helpers
package taus_urng_pkg;

   localparam logic [31:0] MASK1 = 32'hFFFF_FFFE;
   localparam logic [31:0] MASK2 = 32'hFFFF_FFF8;
   localparam logic [31:0] MASK3 = 32'hFFFF_FFF0;

   localparam int S1_A = 13;
   localparam int S1_B = 19;
   localparam int S1_C = 12;
   localparam int S2_A = 2;
   localparam int S2_B = 25;
   localparam int S2_C = 4;
   localparam int S3_A = 3;
   localparam int S3_B = 11;
   localparam int S3_C = 17;

   localparam logic [31:0] DEF_S1 = 32'd12345;
   localparam logic [31:0] DEF_S2 = 32'd12345;
   localparam logic [31:0] DEF_S3 = 32'd12345;

   localparam logic [31:0] MIN_S1 = 32'd2;
   localparam logic [31:0] MIN_S2 = 32'd8;
   localparam logic [31:0] MIN_S3 = 32'd16;

   localparam logic [31:0] GOLDEN = 32'h9E37_79B9;

   typedef struct packed {
      logic [31:0] z1;
      logic [31:0] z2;
      logic [31:0] z3;
   } chan_state_t;

   // Seeds below the minimum would lock a component into an all-zero orbit.
   function automatic chan_state_t guard_seed(input logic [31:0] s1,
                                              input logic [31:0] s2,
                                              input logic [31:0] s3);
      chan_state_t st;
      st.z1 = (s1 < MIN_S1) ? DEF_S1 : s1;
      st.z2 = (s2 < MIN_S2) ? DEF_S2 : s2;
      st.z3 = (s3 < MIN_S3) ? DEF_S3 : s3;
      return st;
   endfunction

   function automatic chan_state_t reset_state(input int unsigned k);
      logic [31:0] mix;
      mix = k * GOLDEN;
      return guard_seed(DEF_S1 ^ mix, DEF_S2 ^ mix, DEF_S3 ^ mix);
   endfunction

endpackage

// File: rtl/taus_urng_step.sv
// rtl/taus_urng_step.sv - one taus88 channel step: current states to next states and sample
module taus_urng_step
   import taus_urng_pkg::*;
(
   input  chan_state_t cur,
   output chan_state_t nxt,
   output logic [31:0] sample
);

   always_comb begin
      nxt.z1 = (((cur.z1 << S1_A) ^ cur.z1) >> S1_B) ^ ((cur.z1 & MASK1) << S1_C);
      nxt.z2 = (((cur.z2 << S2_A) ^ cur.z2) >> S2_B) ^ ((cur.z2 & MASK2) << S2_C);
      nxt.z3 = (((cur.z3 << S3_A) ^ cur.z3) >> S3_B) ^ ((cur.z3 & MASK3) << S3_C);
      sample = nxt.z1 ^ nxt.z2 ^ nxt.z3;
   end

endmodule

// File: rtl/taus_urng_mc.sv
// rtl/taus_urng_mc.sv - multi-channel taus88 URNG with output FIFO; optional SAMPLE_CNT_EN pop counter
module taus_urng_mc
   import taus_urng_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 seed_valid,
   input  logic [3:0]           seed_ch,
   input  logic [31:0]          seed_s1,
   input  logic [31:0]          seed_s2,
   input  logic [31:0]          seed_s3,
   output logic                 seed_err,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [32*NUM_CH-1:0] out_data
`ifdef SAMPLE_CNT_EN
   ,
   output logic [31:0]          sample_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = 32 * NUM_CH;
   localparam logic [AW:0] PTR_ONE = 1;

   chan_state_t   state_q   [NUM_CH];
   chan_state_t   state_d   [NUM_CH];
   chan_state_t   state_nxt [NUM_CH];
   logic [DW-1:0] samples;

   logic [DW-1:0] mem_q [FIFO_DEPTH];
   logic [DW-1:0] mem_d [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          seed_err_q, seed_err_d;

   logic full, empty, pop, push, seed_hit, seed_bad;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      taus_urng_step u_step (
         .cur    (state_q[g]),
         .nxt    (state_nxt[g]),
         .sample (samples[32*g +: 32])
      );
   end

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign seed_hit = seed_valid && ({1'b0, seed_ch} < 5'(NUM_CH));
   assign seed_bad = seed_valid && !seed_hit;
   assign pop      = out_valid && out_ready;
   assign push     = en && !seed_valid && (!full || pop);

   assign out_valid = !empty;
   assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign seed_err  = seed_err_q;

   always_comb begin
      state_d    = state_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      seed_err_d = seed_bad;
      if (seed_hit) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if ({1'b0, seed_ch} == 5'(k)) begin
               state_d[k] = guard_seed(seed_s1, seed_s2, seed_s3);
            end
         end
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            for (int k = 0; k < NUM_CH; k++) begin
               state_d[k] = state_nxt[k];
            end
            mem_d[wr_ptr_q[AW-1:0]] = samples;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            state_q[k] <= reset_state(k);
         end
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         seed_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         seed_err_q <= seed_err_d;
      end
   end

`ifdef SAMPLE_CNT_EN
   logic [31:0] sample_cnt_q, sample_cnt_d;

   always_comb begin
      sample_cnt_d = sample_cnt_q;
      if (seed_hit) begin
         sample_cnt_d = '0;
      end else if (pop) begin
         sample_cnt_d = sample_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sample_cnt_q <= '0;
      end else begin
         sample_cnt_q <= sample_cnt_d;
      end
   end

   assign sample_cnt = sample_cnt_q;
`endif

endmodule

// File: tb/tb_taus_urng_mc.sv
// tb/tb_taus_urng_mc.sv - scoreboard bench for taus_urng_mc against a taus88 reference model
module tb_taus_urng_mc;

   localparam int NUM_CH     = 4;
   localparam int FIFO_DEPTH = 2;
   localparam logic [31:0] FIRST_DEF = 32'h6360_8376;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 en;
   logic                 seed_valid;
   logic [3:0]           seed_ch;
   logic [31:0]          seed_s1, seed_s2, seed_s3;
   logic                 seed_err;
   logic                 out_valid;
   logic                 out_ready;
   logic [32*NUM_CH-1:0] out_data;
`ifdef SAMPLE_CNT_EN
   logic [31:0]          sample_cnt;
`endif

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   logic [127:0] exp_q [$];
   logic         exp_err = 1'b0;
   logic [31:0]  exp_cnt = '0;
   logic [31:0]  m1 [NUM_CH];
   logic [31:0]  m2 [NUM_CH];
   logic [31:0]  m3 [NUM_CH];

   always #5 clk = ~clk;

   taus_urng_mc #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .seed_valid (seed_valid),
      .seed_ch    (seed_ch),
      .seed_s1    (seed_s1),
      .seed_s2    (seed_s2),
      .seed_s3    (seed_s3),
      .seed_err   (seed_err),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
`ifdef SAMPLE_CNT_EN
      ,
      .sample_cnt (sample_cnt)
`endif
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] grd(input logic [31:0] s, input logic [31:0] lim);
      return (s < lim) ? 32'd12345 : s;
   endfunction

   function automatic void model_seed(input int k, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
      m1[k] = grd(a, 32'd2);
      m2[k] = grd(b, 32'd8);
      m3[k] = grd(c, 32'd16);
   endfunction

   function automatic void model_reset();
      logic [31:0] kk;
      for (int k = 0; k < NUM_CH; k++) begin
         kk = 32'(k) * 32'h9E37_79B9;
         model_seed(k, 32'd12345 ^ kk, 32'd12345 ^ kk, 32'd12345 ^ kk);
      end
   endfunction

   function automatic logic [31:0] model_step(input int k);
      logic [31:0] a, b, c;
      a = m1[k]; b = m2[k]; c = m3[k];
      a = (((a << 13) ^ a) >> 19) ^ ((a & 32'hFFFF_FFFE) << 12);
      b = (((b << 2) ^ b) >> 25) ^ ((b & 32'hFFFF_FFF8) << 4);
      c = (((c << 3) ^ c) >> 11) ^ ((c & 32'hFFFF_FFF0) << 17);
      m1[k] = a; m2[k] = b; m3[k] = c;
      return a ^ b ^ c;
   endfunction

   // Predictor: the queue mirrors the DUT FIFO contents after the monitor's pop.
   always @(posedge clk) begin
      logic [127:0] vec;
      if (reset) begin
         exp_q.delete();
         model_reset();
         exp_err = 1'b0;
         exp_cnt = '0;
      end else begin
         exp_err = seed_valid && (seed_ch >= 4'(NUM_CH));
         if (seed_valid) begin
            if (seed_ch < 4'(NUM_CH)) begin
               model_seed(int'(seed_ch), seed_s1, seed_s2, seed_s3);
               exp_q.delete();
               exp_cnt = '0;
            end
         end else if (en && exp_q.size() < FIFO_DEPTH) begin
            vec = '0;
            for (int k = 0; k < NUM_CH; k++) vec[32*k +: 32] = model_step(k);
            exp_q.push_back(vec);
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check("out_valid", out_valid, exp_q.size() != 0);
         check("seed_err", seed_err, exp_err);
`ifdef SAMPLE_CNT_EN
         check("sample_cnt", sample_cnt, exp_cnt);
`endif
         if (exp_q.size() == 0) begin
            check("out_data_empty", out_data, '0);
         end else begin
            check("out_data", out_data, exp_q[0]);
            if (out_ready) begin
               void'(exp_q.pop_front());
               exp_cnt = exp_cnt + 32'd1;
            end
         end
      end
   end

   task automatic step_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic seed_write(input logic [3:0] ch, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c);
      seed_valid = 1'b1; seed_ch = ch; seed_s1 = a; seed_s2 = b; seed_s3 = c;
      step_cycles(1);
      seed_valid = 1'b0;
   endtask

   initial begin
      int cnt;
      reset = 1'b1; en = 1'b0; seed_valid = 1'b0; seed_ch = '0;
      seed_s1 = '0; seed_s2 = '0; seed_s3 = '0; out_ready = 1'b0;
      step_cycles(1);
      mon_en = 1'b1;
      step_cycles(2);
      reset = 1'b0;
      step_cycles(2);

      // Latency: en sampled at the next edge, valid right after it.
      en = 1'b1; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("latency_valid", out_valid, 1'b1);
      check("first_ch0_hand", out_data[31:0], FIRST_DEF);
      step_cycles(1000);

      // Back-pressure: only FIFO_DEPTH vectors may be buffered.
      out_ready = 1'b0;
      step_cycles(10);
      en = 1'b0;
      step_cycles(1);
      out_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("buffered_count", cnt, FIFO_DEPTH);
      step_cycles(1);
      en = 1'b1;
      step_cycles(20);

      // Degenerate seed on ch2 falls back to the default seed.
      seed_write(4'd2, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("flush_valid_low", out_valid, 1'b0);
      @(negedge clk);
      check("ch2_default_first", out_data[95:64], FIRST_DEF);
      step_cycles(20);

      // Out-of-range channel is rejected with a single-cycle error pulse.
      seed_write(4'(NUM_CH), 32'd5, 32'd6, 32'd7);
      @(negedge clk);
      check("seed_err_pulse", seed_err, 1'b1);
      @(negedge clk);
      check("seed_err_clear", seed_err, 1'b0);
      step_cycles(20);

      seed_write(4'd1, 32'd1000, 32'd2000, 32'd3000);
      seed_write(4'd3, 32'd1000, 32'd2000, 32'd3000);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) check("ch1_eq_ch3", out_data[63:32], out_data[127:96]);
      end
      step_cycles(1);

      for (int i = 0; i < 400; i++) begin
         en = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         step_cycles(1);
      end

      // Reset dominates a simultaneous seed write and discards buffered data.
      en = 1'b1; out_ready = 1'b0;
      step_cycles(3);
      reset = 1'b1; seed_valid = 1'b1; seed_ch = 4'd0; seed_s1 = 32'd777;
      step_cycles(1);
      reset = 1'b0; seed_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("post_reset_ch0", out_data[31:0], FIRST_DEF);
      step_cycles(600);

      en = 1'b0;
      step_cycles(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
